fp32_uart_tx: RTL and testbench
===============================

// Module: fp32_uart_tx
// PURPOSE
//   UART transmitter for the FP32 MAC datapath. Latches one NUM_BYTES-wide word
//   through a valid/ready handshake and serialises it as NUM_BYTES consecutive
//   8N1 characters. Sits after the MAC result register and drives the board TX pin.
//   It is the counterpart of fp32_uart_rx and uses the same bit period and byte order.
// PARAMETERS
//   CLKS_PER_BIT  444  clock cycles per UART bit (start, data and stop); legal range >= 2
//   NUM_BYTES     4    bytes per word (4 = one FP32 result; 12 = an RX-format triple); legal range 1..16
// PORTS
//   CLK_I         in   1              single system clock, rising edge
//   RSTL_I        in   1              asynchronous, active-low reset
//   TX_VALID_I    in   1              word on TX_DATA_I is offered
//   TX_DATA_I     in   NUM_BYTES*8    word to send; byte k = TX_DATA_I[8k+7:8k]
//   TX_READY_O    out  1              block idle and able to accept a word
//   TX_DONE_O     out  1              1-cycle pulse when the final stop bit completes
//   UART_TX_O     out  1              serial line; idles high
// BEHAVIOUR
//   Reset (async, RSTL_I=0): UART_TX_O=1, TX_READY_O=1, TX_DONE_O=0, state=IDLE,
//     all counters = 0. A reset mid-frame aborts the frame at once; the line returns high.
//   Handshake: a word is accepted on a rising edge where TX_VALID_I=1 and TX_READY_O=1.
//     TX_DATA_I is copied into an internal shift register on that edge, and TX_READY_O
//     falls on the same edge. TX_VALID_I and TX_DATA_I are ignored while TX_READY_O=0.
//   Wire order: byte 0 is sent first, and each byte is sent LSB first. The result is
//     bit-compatible with the total_index = byte*8 + bit packing in fp32_uart_rx.
//   FSM (all transitions on registered outputs; UART_TX_O is driven from a flop):
//     IDLE  : UART_TX_O=1, TX_READY_O=1. On accept -> START, with clk_cnt=0 and byte_idx=0.
//     START : UART_TX_O=0 for CLKS_PER_BIT cycles, then -> DATA with bit_idx=0.
//     DATA  : UART_TX_O = current bit, held for CLKS_PER_BIT cycles.
//             If bit_idx<7: increment bit_idx and stay in DATA. Otherwise -> STOP.
//     STOP  : UART_TX_O=1 for CLKS_PER_BIT cycles.
//             If byte_idx<NUM_BYTES-1: increment byte_idx and -> START, with no extra idle between bytes.
//             Otherwise -> IDLE; on that edge TX_READY_O=1 and TX_DONE_O=1 (high for 1 cycle).
//   Timing:
//     - UART_TX_O falls on the edge that accepts the word (latency 1 cycle from the sampled valid).
//     - Every bit lasts exactly CLKS_PER_BIT cycles.
//     - TX_READY_O stays low for exactly NUM_BYTES*10*CLKS_PER_BIT cycles.
//   Back-to-back: if TX_VALID_I=1 in the first IDLE cycle, the next word is accepted on
//     the following edge. The last stop bit is therefore CLKS_PER_BIT+1 cycles; this is legal 8N1.
//   Widths: clk_cnt is $clog2(CLKS_PER_BIT) bits, bit_idx is 3 bits, byte_idx is
//     $clog2(NUM_BYTES)+1 bits. clk_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
//   Illegal or unused state encodings -> IDLE, with UART_TX_O=1.
// TESTING
//   1 Assert reset. Check UART_TX_O=1, TX_READY_O=1, TX_DONE_O=0.
//     Hold TX_VALID_I=1 during reset: nothing may be accepted.
//   2 Send 32'h3F80_0000 (1.0f). A mid-bit sampling model must decode the bytes
//     00,00,80,3F in that order, each with start=0 and stop=1.
//     TX_READY_O must stay low for 17760 cycles, and there must be one TX_DONE_O pulse.
//   3 Send 32'h5555_5555. Every line transition inside a byte must be exactly 444 cycles apart.
//     Repeat with CLKS_PER_BIT=4 and NUM_BYTES=1 to check the minimal configuration.
//   4 Hold TX_VALID_I=1 with two words, A=32'hDEAD_BEEF then B=32'h0123_4567.
//     The start bit of B must begin 1 cycle after TX_READY_O rises.
//     Both words must decode correctly, with two TX_DONE_O pulses.
//   5 After acceptance, change TX_DATA_I every cycle and pulse TX_VALID_I.
//     The line must still carry the originally latched word, and no second frame may start.
//   6 Pulse RSTL_I low during byte 2 of a frame. The line must go high immediately, with
//     TX_READY_O=1 and no TX_DONE_O. A following frame must decode cleanly.
//     Separately, loop back NUM_BYTES=12 into fp32_uart_rx: RX_DATA_O must equal the 96-bit word sent.

Source files
------------

// File: rtl/fp32_uart_tx.sv
// fp32_uart_tx: accepts one NUM_BYTES-wide word and sends it as NUM_BYTES 8N1 characters,
// byte 0 first and each byte LSB first.
module fp32_uart_tx #(
    parameter int CLKS_PER_BIT = 444,
    parameter int NUM_BYTES    = 4
) (
    input  logic                   CLK_I,
    input  logic                   RSTL_I,
    input  logic                   TX_VALID_I,
    input  logic [NUM_BYTES*8-1:0] TX_DATA_I,
    output logic                   TX_READY_O,
    output logic                   TX_DONE_O,
    output logic                   UART_TX_O
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NUM_BYTES) + 1;
    localparam int DW = NUM_BYTES * 8;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [DW-1:0] shift_q, shift_d;
    logic          tx_q, tx_d, done_q, done_d, ready_q;
    logic          wrap;

    assign wrap       = clk_cnt_q == CNT_LAST;
    assign UART_TX_O  = tx_q;
    assign TX_DONE_O  = done_q;
    assign TX_READY_O = ready_q;

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = (state_q == IDLE || wrap) ? '0 : clk_cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (TX_VALID_I) begin
                    state_d    = START;
                    tx_d       = 1'b0;
                    shift_d    = TX_DATA_I;
                    byte_idx_d = '0;
                end
            end
            START: if (wrap) begin
                state_d   = DATA;
                bit_idx_d = '0;
                tx_d      = shift_q[0];
            end
            // The shift register advances one bit per data slot, so bit 0 is always the live bit
            DATA: if (wrap) begin
                shift_d = shift_q >> 1;
                if (bit_idx_q != 3'd7) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    tx_d      = shift_q[1];
                end else begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: if (wrap) begin
                if (byte_idx_q != BYTE_LAST) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    state_d    = START;
                    tx_d       = 1'b0;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            ready_q    <= state_d == IDLE;
        end
    end
endmodule

// File: tb/tb_fp32_uart_tx.sv
// tb_fp32_uart_tx: table-driven frame decoding on four configurations plus hand-written
// back-to-back, input-churn and mid-frame reset sequences.
module tb_fp32_uart_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid, rdy, done, line;
    logic [95:0] data_b;

    always #5 clk = ~clk;

    fp32_uart_tx #(.CLKS_PER_BIT(444), .NUM_BYTES(4)) u0 (
        .CLK_I(clk), .RSTL_I(rst_n), .TX_VALID_I(valid[0]), .TX_DATA_I(data_b[31:0]),
        .TX_READY_O(rdy[0]), .TX_DONE_O(done[0]), .UART_TX_O(line[0]));
    fp32_uart_tx #(.CLKS_PER_BIT(16), .NUM_BYTES(4)) u1 (
        .CLK_I(clk), .RSTL_I(rst_n), .TX_VALID_I(valid[1]), .TX_DATA_I(data_b[31:0]),
        .TX_READY_O(rdy[1]), .TX_DONE_O(done[1]), .UART_TX_O(line[1]));
    fp32_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(1)) u2 (
        .CLK_I(clk), .RSTL_I(rst_n), .TX_VALID_I(valid[2]), .TX_DATA_I(data_b[7:0]),
        .TX_READY_O(rdy[2]), .TX_DONE_O(done[2]), .UART_TX_O(line[2]));
    fp32_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(12)) u3 (
        .CLK_I(clk), .RSTL_I(rst_n), .TX_VALID_I(valid[3]), .TX_DATA_I(data_b),
        .TX_READY_O(rdy[3]), .TX_DONE_O(done[3]), .UART_TX_O(line[3]));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          sel;
        logic [95:0] word;
        int          nb;
        int          cpb;
        int          low;
        int          trans;
    } vec_t;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start(input int sel, input logic [95:0] w, input bit hold);
        int t = 0;
        while (rdy[sel] !== 1'b1 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("ready_before_send", {95'd0, rdy[sel]}, 96'd1);
        @(negedge clk);
        data_b     = w;
        valid[sel] = 1'b1;
        @(posedge clk); #1;
        if (!hold) valid[sel] = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; samples each bit at its middle cycle
    task automatic decode(input int sel, input int nb, input int cpb, output logic [95:0] got,
                          output int low, output int ferr, output int trans, output int bad_iv,
                          output int dones);
        int   c      = 0;
        int   last_t = 0;
        logic prev   = 1'b1;
        got = '0; low = 0; ferr = 0; trans = 0; bad_iv = 0; dones = 0;
        while (rdy[sel] === 1'b0 && c < nb * 10 * cpb + 50) begin
            if (done[sel] === 1'b1) dones++;
            if (line[sel] !== prev) begin
                trans++;
                if ((c - last_t) % cpb != 0) bad_iv++;
                last_t = c;
                prev   = line[sel];
            end
            if (c % cpb == cpb / 2) begin
                int idx = c / cpb;
                int k   = idx % 10;
                if (k == 0 && line[sel] !== 1'b0) ferr++;
                else if (k == 9 && line[sel] !== 1'b1) ferr++;
                else if (k > 0 && k < 9 && idx / 10 < 12) got[(idx / 10) * 8 + k - 1] = line[sel];
            end
            low++;
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [95:0] got;
        int low, ferr, trans, bad_iv, dones;
        logic d_end, d_next;
        start(v.sel, v.word, 1'b0);
        decode(v.sel, v.nb, v.cpb, got, low, ferr, trans, bad_iv, dones);
        d_end = done[v.sel];
        @(posedge clk); #1;
        d_next = done[v.sel];
        check({tag, " word"}, got, v.word);
        check({tag, " ready_low"}, 96'(low), 96'(v.low));
        check({tag, " start_stop"}, 96'(ferr), 96'd0);
        check({tag, " transitions"}, 96'(trans), 96'(v.trans));
        check({tag, " bit_spacing"}, 96'(bad_iv), 96'd0);
        check({tag, " done_pulse"}, {93'd0, dones != 0, d_end, d_next}, 96'b010);
    endtask

    initial begin
        vec_t        tv[7];
        logic [95:0] got;
        int          low, ferr, trans, bad_iv, dones;
        tv[0] = '{0, 96'h3F80_0000, 4, 444, 17760, 10};
        tv[1] = '{0, 96'h5555_5555, 4, 444, 17760, 40};
        tv[2] = '{2, 96'h55, 1, 4, 40, 10};
        tv[3] = '{2, 96'hA5, 1, 4, 40, 8};
        tv[4] = '{1, 96'hDEAD_BEEF, 4, 16, 640, 20};
        tv[5] = '{1, 96'h0, 4, 16, 640, 8};
        tv[6] = '{3, 96'h00FF_00FF_A5A5_A5A5_5555_5555, 12, 4, 480, 80};

        rst_n  = 1'b0;
        valid  = 4'hF;
        data_b = '1;
        repeat (5) @(posedge clk);
        #1;
        check("reset ready", {92'd0, rdy}, 96'hF);
        check("reset line", {92'd0, line}, 96'hF);
        check("reset done", {92'd0, done}, 96'h0);
        @(negedge clk);
        valid = 4'h0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset ready", {92'd0, rdy}, 96'hF);
        check("post_reset line", {92'd0, line}, 96'hF);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), tv[i]);

        // Back-to-back: valid held, B must start on the edge after ready rises
        start(1, 96'hDEAD_BEEF, 1'b1);
        data_b = 96'h0123_4567;
        decode(1, 4, 16, got, low, ferr, trans, bad_iv, dones);
        check("b2b A word", got, 96'hDEAD_BEEF);
        check("b2b A ready_low", 96'(low), 96'd640);
        check("b2b A done_at_ready", {95'd0, done[1]}, 96'd1);
        check("b2b A stop_level", {95'd0, line[1]}, 96'd1);
        @(posedge clk); #1;
        valid[1] = 1'b0;
        check("b2b B start_next_cycle", {94'd0, rdy[1], line[1]}, 96'b00);
        check("b2b B no_extra_done", {95'd0, done[1]}, 96'd0);
        decode(1, 4, 16, got, low, ferr, trans, bad_iv, dones);
        check("b2b B word", got, 96'h0123_4567);
        check("b2b B ready_low", 96'(low), 96'd640);
        check("b2b B start_stop", 96'(ferr), 96'd0);
        check("b2b B done", {94'd0, dones != 0, done[1]}, 96'b01);

        // Inputs churn while busy: the latched word must go out and nothing else starts
        repeat (3) @(posedge clk);
        start(1, 96'h3F80_0000, 1'b0);
        fork
            decode(1, 4, 16, got, low, ferr, trans, bad_iv, dones);
            begin
                repeat (600) begin
                    @(negedge clk);
                    data_b   = {$urandom, $urandom, $urandom};
                    valid[1] = ~valid[1];
                end
                valid[1] = 1'b0;
            end
        join
        check("churn word", got, 96'h3F80_0000);
        check("churn ready_low", 96'(low), 96'd640);
        repeat (3) @(posedge clk);
        #1;
        check("churn no_second_frame", {94'd0, rdy[1], line[1]}, 96'b11);

        // Reset during byte 2 aborts the frame immediately
        start(1, 96'hDEAD_BEEF, 1'b0);
        repeat (370) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort line", {95'd0, line[1]}, 96'd1);
        check("abort ready", {95'd0, rdy[1]}, 96'd1);
        check("abort done", {95'd0, done[1]}, 96'd0);
        @(posedge clk); #1;
        check("abort done_held", {95'd0, done[1]}, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after_abort", '{1, 96'h3F80_0000, 4, 16, 640, 10});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
